flanger_core: RTL

- Downstream consumer of the triangle LFO: a modulated delay-line (flanger) stage in the audio effects chain.
- Stores incoming audio samples in a circular buffer and reads a tap whose delay follows the 32-bit signed LFO value.
- Outputs a 50/50 mix of the dry sample and the delayed (wet) sample, one result per accepted input sample.

---
 rtl/flanger_pkg.sv | 19 +
 rtl/flanger_delay_ram.sv | 26 ++
 rtl/flanger_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/flanger_pkg.sv
// Shared types and default constants for the flanger delay-line stage.
// Optional build macro used by this slice: FLANGER_INTERP_EN (two-tap interpolation).
package flanger_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_MIN_DLY = 2;
  localparam int FRAC_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_MIX  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/flanger_delay_ram.sv
// Delay-line storage: one write port, one synchronous read port (1-cycle latency), no reset.
module flanger_delay_ram
  import flanger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write the dry sample and register the read tap every cycle
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/flanger_core.sv
// Modulated delay-line (flanger): mixes each accepted sample 50/50 with an LFO-steered delayed tap.
// Build macro FLANGER_INTERP_EN adds a second tap and linear interpolation between taps.
module flanger_core
  import flanger_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MIN_DLY = DEF_MIN_DLY
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic signed [31:0]       i_lfo,
  input  logic [2:0]               i_depth,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_sample,
  output logic                     o_busy
);

  localparam int MOD_W = ADDR_W - 1;
  localparam logic [ADDR_W:0] D_MAX = (ADDR_W+1)'((2**ADDR_W) - 2);

  state_t            state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] fill_r;
  logic [DATA_W-1:0] dry_r;
  logic [31:0]       lfo_r;
  logic [2:0]        depth_r;
  logic [ADDR_W:0]   d_r;
  logic [DATA_W-1:0] mix_r;

  logic [31:0]       scaled_s;
  logic [MOD_W-1:0]  mod_s;
  logic [ADDR_W:0]   d_sum_s;
  logic [ADDR_W:0]   d_calc_s;
  logic              age0_ok_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] wet_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] mix_s;
  logic              wr_en_s;

`ifdef FLANGER_INTERP_EN
  logic [FRAC_W-1:0]             frac_r;
  logic [DATA_W-1:0]             tap0_r;
  logic [FRAC_W-1:0]             frac_s;
  logic                          age1_ok_s;
  logic [DATA_W-1:0]             tap1_s;
  logic [DATA_W:0]               diff_s;
  logic signed [DATA_W+FRAC_W:0] prod_s;
  logic signed [DATA_W+FRAC_W:0] step_s;
  logic                          unused_scaled_s;
  assign unused_scaled_s = ^scaled_s[31-MOD_W-FRAC_W:0];
`else
  logic unused_scaled_s;
  assign unused_scaled_s = ^scaled_s[31-MOD_W:0];
`endif

  // Delay mapping: offset-binary LFO scaled by depth, integer part sets d, next bits are the fraction
  always_comb begin
    scaled_s = {~lfo_r[31], lfo_r[30:0]} >> (3'd7 - depth_r);
    mod_s    = scaled_s[31 -: MOD_W];
    d_sum_s  = (ADDR_W+1)'(MIN_DLY) + {2'b00, mod_s};
    if (d_sum_s > D_MAX) begin
      d_calc_s = D_MAX;
    end else begin
      d_calc_s = d_sum_s;
    end
`ifdef FLANGER_INTERP_EN
    frac_s = scaled_s[31-MOD_W -: FRAC_W];
`endif
  end

  // Tap addressing, empty-buffer masking and the dry/wet mix
  always_comb begin
    age0_ok_s = (d_r <= {1'b0, fill_r});
    rd_addr_s = wr_ptr_r - d_r[ADDR_W-1:0];
`ifdef FLANGER_INTERP_EN
    age1_ok_s = ((d_r + (ADDR_W+1)'(1)) <= {1'b0, fill_r});
    if (state_r == S_RD1) begin
      rd_addr_s = wr_ptr_r - d_r[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_addr_s = wr_ptr_r - d_r[ADDR_W-1:0];
    end
    tap1_s = age1_ok_s ? rd_data_s : {DATA_W{1'b0}};
    diff_s = {tap1_s[DATA_W-1], tap1_s} - {tap0_r[DATA_W-1], tap0_r};
    prod_s = $signed(diff_s) * $signed({1'b0, frac_r});
    step_s = prod_s >>> FRAC_W;
    wet_s  = tap0_r + step_s[DATA_W-1:0];
`else
    wet_s = age0_ok_s ? rd_data_s : {DATA_W{1'b0}};
`endif
    sum_s   = {dry_r[DATA_W-1], dry_r} + {wet_s[DATA_W-1], wet_s};
    mix_s   = sum_s[DATA_W:1];
    wr_en_s = (state_r == S_OUT);
  end

  flanger_delay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (dry_r),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Sample-processing FSM with registered outputs and datapath captures
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= S_IDLE;
      o_valid  <= 1'b0;
      o_sample <= {DATA_W{1'b0}};
      o_busy   <= 1'b0;
      wr_ptr_r <= {ADDR_W{1'b0}};
      fill_r   <= {ADDR_W{1'b0}};
      dry_r    <= {DATA_W{1'b0}};
      lfo_r    <= 32'd0;
      depth_r  <= 3'd0;
      d_r      <= {(ADDR_W+1){1'b0}};
      mix_r    <= {DATA_W{1'b0}};
`ifdef FLANGER_INTERP_EN
      frac_r   <= {FRAC_W{1'b0}};
      tap0_r   <= {DATA_W{1'b0}};
`endif
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_valid) begin
            dry_r   <= i_sample;
            lfo_r   <= i_lfo;
            depth_r <= i_depth;
            o_busy  <= 1'b1;
            state_r <= S_CALC;
          end
        end
        S_CALC: begin
          d_r     <= d_calc_s;
`ifdef FLANGER_INTERP_EN
          frac_r  <= frac_s;
`endif
          state_r <= S_RD0;
        end
        S_RD0: begin
`ifdef FLANGER_INTERP_EN
          state_r <= S_RD1;
`else
          state_r <= S_MIX;
`endif
        end
`ifdef FLANGER_INTERP_EN
        S_RD1: begin
          tap0_r  <= age0_ok_s ? rd_data_s : {DATA_W{1'b0}};
          state_r <= S_MIX;
        end
`endif
        S_MIX: begin
          mix_r   <= mix_s;
          state_r <= S_OUT;
        end
        S_OUT: begin
          wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (fill_r != {ADDR_W{1'b1}}) begin
            fill_r <= fill_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          o_sample <= mix_r;
          o_valid  <= 1'b1;
          o_busy   <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
